lagd_spi_host_master: RTL
=========================

Name: lagd_spi_host_master

Overview:
- SPI host (initiator) for the LAGD SPI-to-AXI slave port; the opposite end of the link.
- Turns single-word read/write requests into SPI frames: single lane, mode 0, MSB first.
- Returns the read data, or a write acknowledge, on a valid/ready response channel.
- Used in the host-side bridge and the SoC testbench to load L2/Ising-core memories over SPI.

Parameters:
- ClkDiv, 4: clk_i cycles per SCK half-period; legal values are 1 and above.
- AddrWidth, 32: address bits shifted per frame.
- DataWidth, 32: data bits shifted per frame.
- DummyCycles, 8: SCK cycles between the address and the read data, read frames only.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AddrWidth  target address
- req_wdata_i  in  DataWidth  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DataWidth  read data; 0 for writes
- rsp_err_o  out  1  status error (see Optional Feature)
- busy_o  out  1  high from request accept to response handshake
- spi_sck_o  out  1  SPI clock, idles low
- spi_csn_o  out  1  chip select, active low
- spi_sdo_o  out  1  host to device
- spi_sdi_i  in  1  device to host

Behaviour:
- Clocking and reset: one clock, clk_i; asynchronous active-low reset rst_ni.
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, spi_sck_o=0, spi_csn_o=1, spi_sdo_o=0.
- Reset asserted mid-frame: CSN rises and SCK drops immediately (asynchronous); the frame is abandoned with no response.
- Request handshake:
  - Accept on req_valid_i & req_ready_o, in IDLE only.
  - Write, address and data are registered on accept; later input changes are ignored.
  - req_ready_o stays low from accept until the response handshake completes.
- Frame, write: CMD 8'h02, then address, then write data.
- Frame, read: CMD 8'h0B, then address, then DummyCycles bits with SDO=0, then DataWidth bits sampled.
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> (WDATA | DUMMY -> RDATA) -> CS_HOLD -> RESP -> IDLE.
- CS_SETUP:
  - Entered the cycle after accept; CSN low, SCK low.
  - SDO carries CMD bit 7.
  - Lasts ClkDiv cycles.
- Bit timing:
  - Every bit = 2*ClkDiv clk_i cycles: SCK high for the first ClkDiv, low for the second.
  - SDO updates together with the SCK falling edge and holds across the next rising edge.
  - spi_sdi_i is sampled on the clk_i edge that drives SCK 0->1 (device rising edge).
- Bit counter: reloads at each state change (8, AddrWidth, DataWidth, DummyCycles). The state changes on the falling SCK of the last bit.
- Frame length with default widths: write 72 SCK pulses; read 80 (8+32+8+32).
- CS_HOLD: SCK low; CSN held low ClkDiv cycles, then released.
- RESP:
  - rsp_valid_o held until rsp_ready_i.
  - rsp_rdata_o = shifted-in data, MSB first. Writes return 0.
  - rsp_valid_o & rsp_ready_i -> IDLE, with req_ready_o=1 the next cycle.
- Request and response do not overlap: a request presented during RESP waits.
- DummyCycles=0: skip DUMMY and go ADDR -> RDATA.
- ClkDiv=1: SCK = clk_i/2; behaviour otherwise identical.
- Minimum CSN-high gap between frames: 2 clk_i cycles (RESP and IDLE).

Optional Feature:
- Macro: LAGD_SPI_HOST_STATUS_EN.
- Defined:
  - Write frames gain a STATUS state after WDATA: 8 extra SCK bits, SDO=0, status byte sampled from SDI.
  - rsp_err_o = (status != 8'h00), valid with rsp_valid_o. Read frames are unchanged.
  - Write frame becomes 80 pulses.
- Not defined: no STATUS state; rsp_err_o tied 0.

Test Plan:
- Basic write (ClkDiv=2): write addr 32'h1000_0040, data 32'hDEAD_BEEF.
  - Expect: 72 SCK pulses on SDO: 8'h02, 32'h1000_0040, 32'hDEAD_BEEF.
  - Expect: CSN low for 72*4+2+2 cycles.
  - Expect: rsp_valid_o with rdata 0; busy_o falls after the handshake.
- Basic read (ClkDiv=2): read addr 32'h7000_0000; device model drives 32'hCAFE_0123 after 8 dummy bits.
  - Expect: CMD 8'h0B on SDO; rsp_rdata_o=32'hCAFE_0123.
- Backpressure: hold rsp_ready_i=0 for 20 cycles with req_valid_i held high.
  - Expect: rsp_valid_o held, req_ready_o=0, no SCK activity, CSN high.
  - Then rsp_ready_i=1: next frame starts 2 cycles later.
- Reset mid-frame: assert rst_ni low during ADDR bit 10.
  - Expect: CSN=1 and SCK=0 asynchronously; no rsp_valid_o.
  - Next request after reset produces a clean full frame.
- Edge parameters: ClkDiv=1, DummyCycles=0, read of 32'h0000_0004.
  - Expect: SCK toggles every cycle; 72 pulses; correct data returned.
- LAGD_SPI_HOST_STATUS_EN defined: device returns status 8'h05 after a write.
  - Expect: rsp_err_o=1 and 80 SCK pulses.
  - Status 8'h00 gives rsp_err_o=0.

Source files
------------

// File: rtl/lagd_spi_host_master.sv
// SPI host (mode 0, single lane, MSB first) that turns single-word read/write requests into SPI frames.
// Define LAGD_SPI_HOST_STATUS_EN to append an 8-bit status read to write frames and drive rsp_err_o.
module lagd_spi_host_master #(
    parameter int ClkDiv      = 4,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int DummyCycles = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 spi_sck_o,
    output logic                 spi_csn_o,
    output logic                 spi_sdo_o,
    input  logic                 spi_sdi_i
);
    localparam int TxW     = (AddrWidth > DataWidth) ? ((AddrWidth > 8) ? AddrWidth : 8)
                                                     : ((DataWidth > 8) ? DataWidth : 8);
    localparam int MaxBits = (DummyCycles > TxW) ? DummyCycles : TxW;
    localparam int CntW    = $clog2(MaxBits + 1);
    localparam int DivW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [7:0]      CmdWrite = 8'h02;
    localparam logic [7:0]      CmdRead  = 8'h0B;
    localparam logic [DivW-1:0] DivLast  = DivW'(ClkDiv - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
`ifdef LAGD_SPI_HOST_STATUS_EN
        ST_STATUS,
`endif
        ST_CS_HOLD,
        ST_RESP
    } state_t;

    state_t               r_state, w_state_next, w_follow;
    logic [DivW-1:0]      r_div, w_div_next;
    logic                 r_high, w_high_next;
    logic [CntW-1:0]      r_bits, w_bits_next;
    logic [TxW-1:0]       r_tx, w_tx_next;
    logic [DataWidth-1:0] r_rx, w_rx_next;
    logic                 r_write, w_write_next;
    logic [AddrWidth-1:0] r_addr, w_addr_next;
    logic [DataWidth-1:0] r_wdata, w_wdata_next;
    logic                 r_sck, w_sck_next;
    logic                 r_csn, w_csn_next;
    logic                 r_sdo, w_sdo_next;
    logic                 w_tick;
    logic                 w_sample;

    assign w_tick = (r_div == DivLast);
`ifdef LAGD_SPI_HOST_STATUS_EN
    assign w_sample = (r_state == ST_RDATA) || (r_state == ST_STATUS);
`else
    assign w_sample = (r_state == ST_RDATA);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_high  <= 1'b0;
            r_bits  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sck   <= 1'b0;
            r_csn   <= 1'b1;
            r_sdo   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_high  <= w_high_next;
            r_bits  <= w_bits_next;
            r_tx    <= w_tx_next;
            r_rx    <= w_rx_next;
            r_write <= w_write_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_sck   <= w_sck_next;
            r_csn   <= w_csn_next;
            r_sdo   <= w_sdo_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_high_next  = r_high;
        w_bits_next  = r_bits;
        w_tx_next    = r_tx;
        w_rx_next    = r_rx;
        w_write_next = r_write;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_sck_next   = r_sck;
        w_csn_next   = r_csn;
        w_sdo_next   = r_sdo;
        w_div_next   = w_tick ? '0 : r_div + DivW'(1);

        // Which shift state follows the current one once its last bit falls.
        w_follow = ST_CS_HOLD;
        case (r_state)
            ST_CMD:   w_follow = ST_ADDR;
            ST_ADDR:  w_follow = r_write ? ST_WDATA : ((DummyCycles > 0) ? ST_DUMMY : ST_RDATA);
            ST_DUMMY: w_follow = ST_RDATA;
`ifdef LAGD_SPI_HOST_STATUS_EN
            ST_WDATA: w_follow = ST_STATUS;
`endif
            default:  w_follow = ST_CS_HOLD;
        endcase

        case (r_state)
            ST_IDLE: begin
                w_div_next = '0;
                if (req_valid_i) begin
                    w_state_next = ST_CS_SETUP;
                    w_write_next = req_write_i;
                    w_addr_next  = req_addr_i;
                    w_wdata_next = req_wdata_i;
                    w_csn_next   = 1'b0;
                    w_high_next  = 1'b0;
                    w_bits_next  = CntW'(8);
                    w_rx_next    = '0;
                    w_tx_next    = TxW'(req_write_i ? CmdWrite : CmdRead) << (TxW - 8);
                    w_sdo_next   = req_write_i ? CmdWrite[7] : CmdRead[7];
                end
            end
            ST_CS_SETUP: begin
                if (w_tick) begin
                    w_state_next = ST_CMD;
                    w_sck_next   = 1'b1;
                    w_high_next  = 1'b1;
                end
            end
            ST_CS_HOLD: begin
                // First half covers the low phase of the final bit, second half is the CSN hold.
                if (w_tick) begin
                    if (r_high) begin
                        w_state_next = ST_RESP;
                        w_csn_next   = 1'b1;
                        w_high_next  = 1'b0;
                    end else begin
                        w_high_next = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                w_div_next = '0;
                if (rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_high) begin
                        w_sck_next  = 1'b0;
                        w_high_next = 1'b0;
                        if (r_bits == CntW'(1)) begin
                            w_state_next = w_follow;
                            w_tx_next    = '0;
                            w_sdo_next   = 1'b0;
                            case (w_follow)
                                ST_ADDR: begin
                                    w_bits_next = CntW'(AddrWidth);
                                    w_tx_next   = TxW'(r_addr) << (TxW - AddrWidth);
                                    w_sdo_next  = r_addr[AddrWidth-1];
                                end
                                ST_WDATA: begin
                                    w_bits_next = CntW'(DataWidth);
                                    w_tx_next   = TxW'(r_wdata) << (TxW - DataWidth);
                                    w_sdo_next  = r_wdata[DataWidth-1];
                                end
                                ST_DUMMY: w_bits_next = CntW'(DummyCycles);
                                ST_RDATA: w_bits_next = CntW'(DataWidth);
`ifdef LAGD_SPI_HOST_STATUS_EN
                                ST_STATUS: w_bits_next = CntW'(8);
`endif
                                default:  w_bits_next = '0;
                            endcase
                        end else begin
                            w_bits_next = r_bits - CntW'(1);
                            w_tx_next   = r_tx << 1;
                            w_sdo_next  = r_tx[TxW-2];
                        end
                    end else begin
                        w_sck_next  = 1'b1;
                        w_high_next = 1'b1;
                        if (w_sample) begin
                            w_rx_next = {r_rx[DataWidth-2:0], spi_sdi_i};
                        end
                    end
                end
            end
        endcase
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_rdata_o = (rsp_valid_o && !r_write) ? r_rx : '0;
`ifdef LAGD_SPI_HOST_STATUS_EN
    // On write frames the receive register only ever holds the status byte.
    assign rsp_err_o   = rsp_valid_o && r_write && (r_rx[7:0] != 8'h00);
`else
    assign rsp_err_o   = 1'b0;
`endif
    assign spi_sck_o   = r_sck;
    assign spi_csn_o   = r_csn;
    assign spi_sdo_o   = r_sdo;

endmodule
